// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared widths, decoder state encoding and FP code record
package fpcvt_pkg;

  localparam int DATA_W = 13;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    OUT   = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
  } fp_code_t;

endpackage

// File: rtl/twos_negate.sv
// rtl/twos_negate.sv - combinational conditional two's complement negate
module twos_negate
  import fpcvt_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/fp_to_twos_decoder.sv
// rtl/fp_to_twos_decoder.sv - iterative (S,E,F) code to two's complement decoder
module fp_to_twos_decoder
  import fpcvt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_s,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [SIG_W-1:0]  in_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_d
);

  dec_state_e        state_q, state_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic              s_q, s_d;
  logic [DATA_W-1:0] out_d_q, out_d_d;
  logic [DATA_W-1:0] signed_mag;
  fp_code_t          code;

  assign code = '{s: in_s, e: in_e, f: in_f};

  twos_negate #(.W(DATA_W)) u_negate (
    .neg (s_q),
    .x   (mag_q),
    .y   (signed_mag)
  );

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    out_d_d = out_d_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = {{(DATA_W-SIG_W){1'b0}}, code.f};
          cnt_d   = code.e;
          s_d     = code.s;
          state_d = (code.e != '0) ? SHIFT : SIGN;
        end
      end
      SHIFT: begin
        // cnt holds the shifts still owed, so leaving at 1 gives exactly E shifts
        mag_d = mag_q << 1;
        cnt_d = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) state_d = SIGN;
      end
      SIGN: begin
        out_d_d = signed_mag;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      out_d_q <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      out_d_q <= out_d_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_d     = out_d_q;

endmodule

// File: tb/tb_fp_to_twos_decoder.sv
// tb/tb_fp_to_twos_decoder.sv - directed table-driven bench for fp_to_twos_decoder
module tb_fp_to_twos_decoder;
  import fpcvt_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_s;
  logic [EXP_W-1:0]  in_e;
  logic [SIG_W-1:0]  in_f;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_d;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [SIG_W-1:0]  f;
    logic [DATA_W-1:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  fp_to_twos_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_f      (in_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Drive one code at a negedge, scramble the inputs after the accept edge,
  // then measure the number of negedge samples until out_valid rises.
  task automatic send_code(input logic s, input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] f,
                           output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_s = s;
    in_e = e;
    in_f = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_s = ~s;
    in_e = ~e;
    in_f = ~f;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  initial begin
    int lat;
    logic [DATA_W-1:0] held;

    vecs[0] = '{1'b0, 3'd0, 5'd22, 13'd22};
    vecs[1] = '{1'b0, 3'd7, 5'd31, 13'h0F80};
    vecs[2] = '{1'b1, 3'd3, 5'd17, 13'h1F78};
    vecs[3] = '{1'b1, 3'd5, 5'd0,  13'h0000};
    vecs[4] = '{1'b0, 3'd1, 5'd1,  13'd2};
    vecs[5] = '{1'b1, 3'd7, 5'd31, 13'h1080};
    vecs[6] = '{1'b0, 3'd4, 5'd9,  13'd144};
    vecs[7] = '{1'b1, 3'd0, 5'd1,  13'h1FFF};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_s = 1'b0;
    in_e = '0;
    in_f = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_d", {19'd0, out_d}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_code(vecs[i].s, vecs[i].e, vecs[i].f, lat);
      check($sformatf("latency_%0d", i), lat, 32'(vecs[i].e) + 32'd2);
      check($sformatf("out_d_%0d", i), {19'd0, out_d}, {19'd0, vecs[i].exp_d});
      @(negedge clk);
      check($sformatf("idle_after_%0d", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: result held 4 cycles, a code offered meanwhile must be ignored
    out_ready = 1'b0;
    send_code(1'b0, 3'd2, 5'd5, lat);
    check("bp_latency", lat, 32'd4);
    held = out_d;
    check("bp_out_d", {19'd0, held}, 32'd20);
    in_valid = 1'b1;
    in_s = 1'b1;
    in_e = 3'd0;
    in_f = 5'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_d_%0d", c), {19'd0, out_d}, 32'd20);
      check($sformatf("bp_hold_flags_%0d", c), {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_flags", {30'd0, out_valid, in_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("bp_no_late_capture", {30'd0, out_valid, in_ready}, 32'd1);
    check("bp_d_after", {19'd0, out_d}, 32'd20);

    // Reset in the middle of shifting aborts the in-flight code
    in_valid = 1'b1;
    in_s = 1'b0;
    in_e = 3'd6;
    in_f = 5'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out_d", {19'd0, out_d}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_code(1'b0, 3'd1, 5'd1, lat);
    check("post_reset_latency", lat, 32'd3);
    check("post_reset_out_d", {19'd0, out_d}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
